// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter with rotates, valid/ready handshake and tag passthrough
module shifter_pipe #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_sh_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  // Stage registers. The last stage only needs valid/data/tag because nothing
  // downstream looks at its op, amount or sign.
  logic [SHW-1:0]   r_valid;
  logic [WIDTH-1:0] r_data [SHW];
  logic [TAG_W-1:0] r_tag  [SHW];
  logic [2:0]       r_op   [SHW-1];
  logic [SHW-1:0]   r_amt  [SHW-1];
  logic [SHW-2:0]   r_sign;

  // Per-stage sources: stage 0 reads the input port, stage k reads stage k-1.
  logic [SHW-1:0]   w_src_valid;
  logic [WIDTH-1:0] w_src_data [SHW];
  logic [TAG_W-1:0] w_src_tag  [SHW];
  logic [2:0]       w_src_op   [SHW];
  logic [SHW-1:0]   w_src_amt  [SHW];
  logic [SHW-1:0]   w_src_sign;
  logic [WIDTH-1:0] w_step     [SHW];

  logic w_adv;
  logic w_load;

  // The pipe moves as one unit; bubbles advance too, so only a held output stalls it.
  assign w_adv    = !r_valid[SHW-1] || out_ready;
  // flush blocks acceptance so the killed cycle cannot smuggle in a new op.
  assign w_load   = w_adv && !flush;
  assign in_ready = w_load;

  assign out_valid  = r_valid[SHW-1];
  assign out_result = r_data[SHW-1];
  assign out_tag    = r_tag[SHW-1];

  for (genvar gk = 0; gk < SHW; gk++) begin : g_stage
    // Distance this stage moves the data when its amount bit is set.
    localparam int S = 1 << gk;

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_res;

    if (gk == 0) begin : g_first
      assign w_src_valid[gk] = in_valid;
      assign w_src_data[gk]  = in_a;
      assign w_src_tag[gk]   = in_tag;
      assign w_src_op[gk]    = in_op;
      assign w_src_amt[gk]   = in_sh_amt;
      // Sign is taken from the original operand once and carried, since
      // later stages only see partially shifted data.
      assign w_src_sign[gk]  = in_a[WIDTH-1];
    end else begin : g_next
      assign w_src_valid[gk] = r_valid[gk-1];
      assign w_src_data[gk]  = r_data[gk-1];
      assign w_src_tag[gk]   = r_tag[gk-1];
      assign w_src_op[gk]    = r_op[gk-1];
      assign w_src_amt[gk]   = r_amt[gk-1];
      assign w_src_sign[gk]  = r_sign[gk-1];
    end

    assign w_d   = w_src_data[gk];
    assign w_sll = w_d << S;
    assign w_srl = w_d >> S;
    assign w_sra = w_srl | ({WIDTH{w_src_sign[gk]}} & ~({WIDTH{1'b1}} >> S));
    assign w_rol = (w_d << S) | (w_d >> (WIDTH - S));
    assign w_ror = (w_d >> S) | (w_d << (WIDTH - S));

    // Select this stage's partial shift; unknown ops and clear amount bits pass data through.
    always_comb begin
      w_res = w_d;
      if (w_src_amt[gk][gk]) begin
        case (w_src_op[gk])
          OP_SLL:  w_res = w_sll;
          OP_SRL:  w_res = w_srl;
          OP_SRA:  w_res = w_sra;
          OP_ROL:  w_res = w_rol;
          OP_ROR:  w_res = w_ror;
          default: w_res = w_d;
        endcase
      end
    end

    assign w_step[gk] = w_res;
  end

  // Pipeline state: valid bits follow flush/advance; payload loads only for live
  // entries so the output holds its last value while idle or after a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_sign  <= '0;
      for (int k = 0; k < SHW; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
      for (int k = 0; k < SHW - 1; k++) begin
        r_op[k]  <= '0;
        r_amt[k] <= '0;
      end
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else if (w_adv) begin
        r_valid <= w_src_valid;
      end
      for (int k = 0; k < SHW; k++) begin
        if (w_load && w_src_valid[k]) begin
          r_data[k] <= w_step[k];
          r_tag[k]  <= w_src_tag[k];
        end
      end
      for (int k = 0; k < SHW - 1; k++) begin
        if (w_load && w_src_valid[k]) begin
          r_op[k]   <= w_src_op[k];
          r_amt[k]  <= w_src_amt[k];
          r_sign[k] <= w_src_sign[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - scoreboard bench for shifter_pipe
module tb_shifter_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int SHW   = 5;

  typedef struct {
    logic [31:0] exp;
    logic [4:0]  tag;
    int          acc;
    bit          lat;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [SHW-1:0]   in_sh_amt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
    .in_sh_amt(in_sh_amt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [4:0] amt);
    logic [63:0]        dbl;
    logic signed [31:0] s;
    dbl = {a, a};
    case (op)
      3'b011: return a << amt;
      3'b100: return a >> amt;
      3'b101: begin s = $signed(a); s = s >>> amt; return s; end
      3'b110: begin dbl = dbl << amt; return dbl[63:32]; end
      3'b111: begin dbl = dbl >> amt; return dbl[31:0]; end
      default: return a;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] a, input logic [4:0] amt,
                       input logic [4:0] tag, input bit ordy, input bit fl, input bit lit,
                       input logic [31:0] lit_exp, input bit lat, output bit acc, output bit rdy);
    ent_t e;
    @(negedge clk);
    in_valid = v; in_op = op; in_a = a; in_sh_amt = amt; in_tag = tag;
    out_ready = ordy; flush = fl;
    #4;
    rdy = in_ready;
    chk(in_ready === ((!out_valid || out_ready) && !flush), "in_ready", in_ready,
        (!out_valid || out_ready) && !flush);
    acc = v && in_ready;
    if (acc) begin
      e.exp = lit ? lit_exp : ref_model(op, a, amt);
      e.tag = tag;
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    if (fl) sb.delete();
  endtask

  task automatic idle(input int n);
    bit a, r;
    for (int i = 0; i < n; i++) drive(0, 3'b000, 32'h0, 5'd0, 5'd0, 1, 0, 0, 32'h0, 0, a, r);
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks hold during stalls.
  initial begin : monitor
    bit          prev_stall;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    ent_t        e;
    prev_stall = 0;
    prev_res = '0;
    prev_tag = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk(out_valid === 1'b1, "hold_valid", out_valid, 1);
          chk(out_result === prev_res, "hold_result", out_result, prev_res);
          chk(out_tag === prev_tag, "hold_tag", out_tag, prev_tag);
        end
        if (out_valid === 1'b1) begin
          chk(sb.size() > 0, "unexpected_out", out_result, 0);
          if (sb.size() > 0 && out_ready) begin
            e = sb.pop_front();
            chk(out_result === e.exp, "result", out_result, e.exp);
            chk(out_tag === e.tag, "tag", out_tag, e.tag);
            if (e.lat) chk(cyc - e.acc == SHW, "latency", cyc - e.acc, SHW);
          end
        end
        prev_stall = out_valid && !out_ready && !flush;
        prev_res = out_result;
        prev_tag = out_tag;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit          acc, rdy;
    int          idx, low_rdy, amt_pick;
    logic [2:0]  op_t [5];
    logic [31:0] exp_t [5];
    op_t  = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    exp_t = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h0000_0F18, 32'h1800_000F};

    rst = 1; flush = 0; in_valid = 0; in_op = 0; in_a = 0; in_sh_amt = 0; in_tag = 0; out_ready = 0;

    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #4;
      chk(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
      chk(out_result === 32'h0, "rst_out_result", out_result, 0);
      chk(in_ready === 1'b1, "rst_in_ready", in_ready, 1);
    end
    rst = 0;

    // Modes, one per cycle
    for (int i = 0; i < 5; i++)
      drive(1, op_t[i], 32'h8000_00F1, 5'd4, 5'(i), 1, 0, 1, exp_t[i], 1, acc, rdy);
    idle(7);

    // Boundaries
    drive(1, 3'b101, 32'hFFFF_0000, 5'd0,  5'd1, 1, 0, 1, 32'hFFFF_0000, 1, acc, rdy);
    drive(1, 3'b101, 32'h8000_0000, 5'd31, 5'd2, 1, 0, 1, 32'hFFFF_FFFF, 1, acc, rdy);
    drive(1, 3'b111, 32'h0000_0001, 5'd31, 5'd3, 1, 0, 1, 32'h0000_0002, 1, acc, rdy);
    // Illegal op passes through
    drive(1, 3'b010, 32'hDEAD_BEEF, 5'd9,  5'h1A, 1, 0, 1, 32'hDEAD_BEEF, 1, acc, rdy);
    idle(7);

    // Back-pressure: tags 0..7, consumer stalls in cycles 6-9
    idx = 0;
    low_rdy = 0;
    for (int i = 0; i < 40 && (idx < 8 || sb.size() > 0); i++) begin
      drive(idx < 8, 3'($urandom_range(3, 7)), $urandom, 5'($urandom_range(0, 31)), 5'(idx),
            !(i >= 6 && i <= 9), 0, 0, 32'h0, 0, acc, rdy);
      if (idx < 8 && !rdy) low_rdy++;
      if (acc) idx++;
    end
    chk(idx == 8, "bp_all_accepted", idx, 8);
    chk(low_rdy > 0, "bp_in_ready_low", low_rdy, 1);
    chk(sb.size() == 0, "bp_drained", sb.size(), 0);

    // Flush with 3 ops in flight and a simultaneous offer
    for (int i = 0; i < 3; i++)
      drive(1, 3'b011, $urandom, 5'd1, 5'(i), 1, 0, 0, 32'h0, 0, acc, rdy);
    drive(1, 3'b100, 32'h1234_5678, 5'd2, 5'd9, 1, 1, 0, 32'h0, 0, acc, rdy);
    chk(!acc, "flush_no_accept", acc, 0);
    for (int i = 0; i < 7; i++) begin
      idle(1);
      chk(out_valid === 1'b0, "flush_out_valid", out_valid, 0);
    end
    drive(1, 3'b110, 32'hA5A5_0001, 5'd8, 5'd7, 1, 0, 1, 32'hA500_01A5, 1, acc, rdy);
    idle(7);

    // Reset mid-operation discards everything in flight
    for (int i = 0; i < 3; i++)
      drive(1, 3'b111, $urandom, 5'd3, 5'(i), 1, 0, 0, 32'h0, 0, acc, rdy);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    #4;
    chk(out_valid === 1'b0, "midrst_out_valid", out_valid, 0);
    chk(out_result === 32'h0, "midrst_out_result", out_result, 0);
    sb.delete();
    @(negedge clk);
    rst = 0;
    idle(7);

    // Randomised traffic with stalls and occasional flushes
    for (int i = 0; i < 600; i++) begin
      amt_pick = $urandom_range(0, 9);
      drive($urandom_range(0, 3) != 0, 3'($urandom), $urandom,
            (amt_pick == 0) ? 5'd0 : (amt_pick == 1) ? 5'd31 : 5'($urandom_range(0, 31)),
            5'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
            0, 32'h0, 0, acc, rdy);
    end

    // Drain
    for (int i = 0; i < 100 && sb.size() > 0; i++) idle(1);
    chk(sb.size() == 0, "final_drain", sb.size(), 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
